// File: rtl/relay_pkg.sv
// relay_pkg
// Shared definitions for the latching-relay bank driver:
//   - relay_state_e : sequencer states (IDLE, PULSE, GAP)
//   - CLK_HZ, PULSE_10MS, GAP_1MS : default timing for the 22.1184 MHz logger clock
//   - cycles_from_ms() : converts a duration in milliseconds to clock cycles
package relay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } relay_state_e;

  localparam int unsigned CLK_HZ     = 32'd22118400;
  localparam int unsigned PULSE_10MS = 32'd221184;
  localparam int unsigned GAP_1MS    = 32'd22118;

  // Product is formed in 64 bits so long durations at the full clock
  // rate cannot overflow before the divide; the result truncates.
  function automatic int unsigned cycles_from_ms(input int unsigned ms,
                                                 input int unsigned clk_hz);
    logic [63:0] prod;
    prod = 64'(clk_hz) * 64'(ms);
    return 32'(prod / 64'd1000);
  endfunction

endpackage

// File: rtl/relay_pulse_timer.sv
// relay_pulse_timer
// Loadable down-counter with a zero flag; times both the coil on-phase
// and the all-off dead time of the relay bank driver.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous, active-low reset (counter -> 0)
//   load_i     in  load load_val_i on this edge
//   load_val_i in  CNT_W  cycles remaining minus one for the new phase
//   zero_o     out counter has reached zero (phase ends on the next edge)
module relay_pulse_timer
  import relay_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load always wins; otherwise count down and park at zero rather
  // than wrapping, so a stale count can never re-open a phase.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/relay_bank_driver.sv
// relay_bank_driver
// Drives a bank of NUM_CH dual-coil latching relays, one timed coil pulse
// at a time with an all-off dead time after every pulse, and remembers the
// commanded state of each relay so the whole bank can be re-pulsed.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_ch, cmd_on        target channel; 1 = set coil (p), 0 = reset coil (n)
//   refresh               one-cycle request to re-pulse every channel
//   relay_p, relay_n      set / reset coil drives
//   state_q               last commanded state per channel
//   busy                  pulse, gap or refresh in progress or pending
//   done                  strobe when a command or a full refresh completes
//   cmd_err               strobe when an out-of-range channel was accepted
module relay_bank_driver
  import relay_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PULSE_CYC     = int'(cycles_from_ms(32'd10, CLK_HZ)),
  parameter int GAP_CYC       = int'(cycles_from_ms(32'd1, CLK_HZ)),
  parameter int INIT_ON_RESET = 1,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic              cmd_on,
  input  logic              refresh,
  output logic [NUM_CH-1:0] relay_p,
  output logic [NUM_CH-1:0] relay_n,
  output logic [NUM_CH-1:0] state_q,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  // The timer holds "cycles left after this one", hence the minus one.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

  relay_state_e      fsm_q, fsm_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic              ref_act_q, ref_act_d;
  logic              ref_pend_q, ref_pend_d;
  logic [NUM_CH-1:0] stored_q, stored_d;
  logic [NUM_CH-1:0] relay_p_q, relay_p_d;
  logic [NUM_CH-1:0] relay_n_q, relay_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic              coil_set, coil_clr, coil_pol;
  logic [CH_W-1:0]   coil_ch;
  logic [NUM_CH-1:0] coil_onehot;
  logic [CH_W-1:0]   next_idx;
  logic              cmd_in_range;

  assign next_idx     = idx_q + CH_W'(1);
  assign cmd_in_range = ({1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH));
  assign cmd_ready    = (fsm_q == IDLE) && !ref_act_q && !ref_pend_q;

  relay_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Sequencer: a pending refresh beats a waiting command, each pulse is
  // followed by its dead time, and a refresh walks GAP -> PULSE through
  // the channels without touching IDLE. A refresh request that arrives
  // while one is running is remembered in ref_pend and re-runs afterwards.
  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    ref_act_d  = ref_act_q;
    ref_pend_d = ref_pend_q | refresh;
    stored_d   = stored_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = PULSE_LOAD;
    coil_set   = 1'b0;
    coil_clr   = 1'b0;
    coil_ch    = '0;
    coil_pol   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (ref_pend_q) begin
          ref_pend_d = 1'b0;
          ref_act_d  = 1'b1;
          idx_d      = '0;
          fsm_d      = PULSE;
          tmr_load   = 1'b1;
          coil_set   = 1'b1;
          coil_ch    = '0;
          coil_pol   = stored_q[0];
        end else if (cmd_valid && cmd_ready) begin
          if (cmd_in_range) begin
            stored_d[cmd_ch] = cmd_on;
            idx_d            = cmd_ch;
            fsm_d            = PULSE;
            tmr_load         = 1'b1;
            coil_set         = 1'b1;
            coil_ch          = cmd_ch;
            coil_pol         = cmd_on;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          fsm_d    = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          coil_clr = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (ref_act_q && (idx_q != LAST_CH)) begin
            idx_d    = next_idx;
            fsm_d    = PULSE;
            tmr_load = 1'b1;
            coil_set = 1'b1;
            coil_ch  = next_idx;
            coil_pol = stored_q[next_idx];
          end else begin
            fsm_d     = IDLE;
            done_d    = 1'b1;
            ref_act_d = 1'b0;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // One-hot select of the coil being energised.
  always_comb begin
    coil_onehot          = '0;
    coil_onehot[coil_ch] = 1'b1;
  end

  // Coil drives only move on PULSE entry and exit, and only one coil of
  // one relay is ever selected, which keeps the supply current bounded.
  always_comb begin
    relay_p_d = relay_p_q;
    relay_n_d = relay_n_q;
    if (coil_set) begin
      relay_p_d = coil_pol ? coil_onehot : '0;
      relay_n_d = coil_pol ? '0 : coil_onehot;
    end else if (coil_clr) begin
      relay_p_d = '0;
      relay_n_d = '0;
    end
  end

  // State registers; reset cuts any coil pulse immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q      <= IDLE;
      idx_q      <= '0;
      ref_act_q  <= 1'b0;
      ref_pend_q <= (INIT_ON_RESET != 0);
      stored_q   <= '0;
      relay_p_q  <= '0;
      relay_n_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      ref_act_q  <= ref_act_d;
      ref_pend_q <= ref_pend_d;
      stored_q   <= stored_d;
      relay_p_q  <= relay_p_d;
      relay_n_q  <= relay_n_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign relay_p = relay_p_q;
  assign relay_n = relay_n_q;
  assign state_q = stored_q;
  assign done    = done_q;
  assign cmd_err = err_q;
  assign busy    = (fsm_q != IDLE) || ref_act_q || ref_pend_q;

endmodule
